// File: rtl/fft16_pkg.sv
// Shared constants, state encoding, twiddle tables and output scaling for the 16-point DFT engine.
package fft16_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NPTS      = 16;
  localparam int unsigned LOG2_NPTS = 4;
  localparam int unsigned TW_W      = 9;
  localparam int unsigned ACC_W     = 20;
  localparam int unsigned PROD_W    = DATA_W + TW_W;
  localparam int unsigned NBYTES    = 2 * NPTS;
  localparam int unsigned BEAT_W    = 5;
  localparam int unsigned SCALE_SH  = 11;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, SEND} state_t;

  typedef logic signed [TW_W-1:0]  tw_t;
  typedef logic [LOG2_NPTS-1:0]    idx_t;
  typedef logic [BEAT_W-1:0]       beat_t;

  localparam idx_t  IDX_LAST  = idx_t'(NPTS - 1);
  localparam beat_t BEAT_LAST = beat_t'(NBYTES - 1);

  localparam logic signed [ACC_W-1:0] ROUND_C = 1024;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -128;

  // Q2.7 samples of cos/sin(2*pi*i/16)
  localparam tw_t COS_ROM [NPTS] = '{
    9'sd128,  9'sd118,  9'sd91,   9'sd49,   9'sd0,   -9'sd49,  -9'sd91,  -9'sd118,
    -9'sd128, -9'sd118, -9'sd91,  -9'sd49,  9'sd0,    9'sd49,   9'sd91,   9'sd118};
  localparam tw_t SIN_ROM [NPTS] = '{
    9'sd0,    9'sd49,   9'sd91,   9'sd118,  9'sd128,  9'sd118,  9'sd91,   9'sd49,
    9'sd0,   -9'sd49,  -9'sd91,  -9'sd118, -9'sd128, -9'sd118, -9'sd91,  -9'sd49};

  // Divide by 16 (plus the Q2.7 twiddle gain) with round-half-up, then clamp to a signed byte.
  function automatic logic [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + ROUND_C) >>> SCALE_SH;
    if (r > SAT_MAX)      return DATA_W'(SAT_MAX);
    else if (r < SAT_MIN) return DATA_W'(SAT_MIN);
    else                  return DATA_W'(r);
  endfunction

endpackage

// File: rtl/fft16_if.sv
// Sample-in, config and result-out stream channels of the DFT engine.
interface fft16_if;
  import fft16_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DATA_W-1:0] config_data;
  logic              config_valid;
  logic              config_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output in_data, in_valid, in_last, config_data, config_valid, out_ready,
    input  in_ready, config_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, config_data, config_valid, out_ready,
    output in_ready, config_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/fft16_twiddle_rom.sv
// Combinational twiddle lookup: index 0..15 -> Q2.7 cos and sin.
module fft16_twiddle_rom
  import fft16_pkg::*;
(
  input  idx_t idx,
  output tw_t  cos_val,
  output tw_t  sin_val
);

  always_comb begin
    cos_val = COS_ROM[idx];
    sin_val = SIN_ROM[idx];
  end

endmodule

// File: rtl/top_wrapper_5.sv
// 16-point DFT engine: loads a real frame, runs one complex MAC per cycle, streams Re/Im bytes per bin.
module top_wrapper_5
  import fft16_pkg::*;
(
  input logic    aclk,
  input logic    aresetn,
  fft16_if.slave bus
);

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] x [NPTS];
  logic [DATA_W-1:0]        obuf [NBYTES];
  idx_t                     wcnt, k, n, tw_idx, prod_k;
  logic                     dir, calc_done, prod_vld, prod_last;
  tw_t                      cos_val, sin_val;
  logic signed [PROD_W-1:0] mul_re, mul_im, prod_re, prod_im;
  logic signed [ACC_W-1:0]  acc_re, acc_im, sum_re, sum_im;
  beat_t                    beat, beat_nxt;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid, out_last;
  logic                     in_hs, cfg_hs, out_hs, frame_close;

  assign bus.in_ready     = ~aresetn & (state == IDLE || state == LOAD);
  assign bus.config_ready = ~aresetn & (state == IDLE);
  assign bus.out_data     = out_data;
  assign bus.out_valid    = out_valid;
  assign bus.out_last     = out_last;

  assign in_hs       = bus.in_valid & bus.in_ready;
  assign cfg_hs      = bus.config_valid & bus.config_ready;
  assign out_hs      = out_valid & bus.out_ready;
  assign frame_close = in_hs & (bus.in_last | (state == LOAD && wcnt == IDX_LAST));

  assign tw_idx   = k * n;
  assign mul_re   = PROD_W'(x[n]) * PROD_W'(cos_val);
  assign mul_im   = PROD_W'(x[n]) * PROD_W'(sin_val);
  assign sum_re   = acc_re + ACC_W'(prod_re);
  assign sum_im   = acc_im + ACC_W'(prod_im);
  assign beat_nxt = beat + beat_t'(1);

  fft16_twiddle_rom u_rom (
    .idx     (tw_idx),
    .cos_val (cos_val),
    .sin_val (sin_val)
  );

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs) state_nxt = bus.in_last ? CALC : LOAD;
      LOAD:    if (frame_close) state_nxt = CALC;
      CALC:    if (calc_done) state_nxt = SEND;
      SEND:    if (out_hs && beat == BEAT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // First sample of a frame wipes the store so short frames are zero-filled.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      for (int unsigned i = 0; i < NPTS; i++) x[i] <= '0;
      wcnt <= '0;
      dir  <= 1'b1;
    end else begin
      if (cfg_hs) dir <= bus.config_data[0];
      if (in_hs) begin
        if (state == IDLE) begin
          for (int unsigned i = 1; i < NPTS; i++) x[i] <= '0;
          x[0] <= bus.in_data;
          wcnt <= idx_t'(1);
        end else begin
          x[wcnt] <= bus.in_data;
          wcnt    <= wcnt + idx_t'(1);
        end
      end
    end
  end

  // Product stage is registered; the accumulate stage below trails it by one cycle.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      k         <= '0;
      n         <= '0;
      calc_done <= 1'b0;
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
      prod_k    <= '0;
      prod_re   <= '0;
      prod_im   <= '0;
    end else begin
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
      if (frame_close) begin
        k         <= '0;
        n         <= '0;
        calc_done <= 1'b0;
      end else if (state == CALC) begin
        if (calc_done) begin
          calc_done <= 1'b0;
        end else begin
          prod_vld  <= 1'b1;
          prod_last <= (n == IDX_LAST);
          prod_k    <= k;
          prod_re   <= mul_re;
          prod_im   <= dir ? -mul_im : mul_im;
          n         <= n + idx_t'(1);
          if (n == IDX_LAST) k <= k + idx_t'(1);
          if (k == IDX_LAST && n == IDX_LAST) calc_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      acc_re <= '0;
      acc_im <= '0;
      for (int unsigned i = 0; i < NBYTES; i++) obuf[i] <= '0;
    end else if (prod_vld) begin
      if (prod_last) begin
        obuf[{prod_k, 1'b0}] <= scale_sat(sum_re);
        obuf[{prod_k, 1'b1}] <= scale_sat(sum_im);
        acc_re <= '0;
        acc_im <= '0;
      end else begin
        acc_re <= sum_re;
        acc_im <= sum_im;
      end
    end
  end

  // Entering SEND costs one cycle to present beat 0 from the buffer.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      beat      <= '0;
    end else if (state == SEND) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= obuf[0];
        out_last  <= 1'b0;
        beat      <= '0;
      end else if (bus.out_ready) begin
        if (beat == BEAT_LAST) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_last  <= 1'b0;
          beat      <= '0;
        end else begin
          out_data <= obuf[beat_nxt];
          out_last <= (beat_nxt == BEAT_LAST);
          beat     <= beat_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_top_wrapper_5.sv
// Scoreboard bench for top_wrapper_5: a real-valued DFT model queues expected beats, a monitor checks them.
module tb_top_wrapper_5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft16_if bus ();

  top_wrapper_5 dut (
    .aclk    (clk),
    .aresetn (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_beat_t;

  exp_beat_t   exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned close_cyc = 0;
  bit          first_pending = 0;
  bit          was_valid = 0;
  bit          stalled = 0;
  bit          stall_mode = 0;
  bit          rand_ready = 0;
  bit          model_fwd = 1;
  logic [7:0]  held_data;
  logic        held_last;
  int          beats_in_frame = 0;
  int          stall_left = 0;
  int          cos_t[16];
  int          sin_t[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int scale(input int acc);
    int r;
    r = int'($floor(real'(acc) / 2048.0 + 0.5));
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic model_push(input int xs[16], input bit fwd);
    exp_beat_t b;
    for (int kk = 0; kk < 16; kk++) begin
      int re = 0;
      int im = 0;
      for (int nn = 0; nn < 16; nn++) begin
        int t = (kk * nn) % 16;
        re += xs[nn] * cos_t[t];
        im += fwd ? -(xs[nn] * sin_t[t]) : xs[nn] * sin_t[t];
      end
      b.data = 8'(scale(re)); b.last = 1'b0;
      exp_q.push_back(b);
      b.data = 8'(scale(im)); b.last = (kk == 15);
      exp_q.push_back(b);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_sample(input logic [7:0] d, input logic l);
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    for (int w = 0; w < 2000; w++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("in_ready_timeout", bus.in_ready, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_cfg(input logic [7:0] d);
    bus.config_data  = d;
    bus.config_valid = 1'b1;
    for (int w = 0; w < 2000; w++) begin
      if (bus.config_ready) begin
        @(posedge clk);
        #1;
        bus.config_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("config_ready_timeout", bus.config_ready, 1);
    bus.config_valid = 1'b0;
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_config_ready"}, bus.config_ready, 0);
  endtask

  // cfg_mode: 0 = keep direction, 1 = config before frame, 2 = config with first sample
  task automatic run_frame(input int xs[16], input int len, input bit tag_last, input int cfg_mode,
                           input logic [7:0] cfg, input bit noise, input bit abort);
    int full[16];
    for (int i = 0; i < 16; i++) full[i] = (i < len) ? xs[i] : 0;
    if (cfg_mode == 1) send_cfg(cfg);
    if (cfg_mode != 0) model_fwd = cfg[0];
    for (int i = 0; i < len; i++) begin
      if (cfg_mode == 2 && i == 0) begin
        bus.config_data  = cfg;
        bus.config_valid = 1'b1;
      end
      if (noise && i == 1) begin
        bus.config_data  = {7'h2a, ~model_fwd};
        bus.config_valid = 1'b1;
      end
      put_sample(8'(xs[i]), (i == len - 1) && (tag_last || len < 16));
      if (cfg_mode == 2 && i == 0) bus.config_valid = 1'b0;
      if (i < len - 1) idle($urandom_range(0, 3) == 0 ? 1 : 0);
    end
    close_cyc = cyc;
    bus.config_valid = 1'b0;
    if (!abort) begin
      model_push(full, model_fwd);
      first_pending = 1;
    end
    if (noise) begin
      bus.in_data  = 8'h5a;
      bus.in_last  = 1'b1;
      bus.in_valid = 1'b1;
      idle(20);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
    if (abort) begin
      idle(100);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        idle(1);
        reset_outputs_check("abort_rst");
      end
      rst = 1'b0;
      model_fwd = 1;
      for (int i = 0; i < 6; i++) begin
        idle(50);
        check("abort_no_out_valid", bus.out_valid, 0);
      end
    end else begin
      for (int w = 0; w < 3000 && exp_q.size() > 0; w++) idle(1);
      if (exp_q.size() > 0) begin
        check("drain_timeout_left", exp_q.size(), 0);
        exp_q.delete();
      end
      idle(3);
    end
  endtask

  // Monitor: checks every output handshake against the scoreboard, plus latency and stall hold.
  always @(negedge clk) begin
    if (rst) begin
      beats_in_frame = 0;
      stalled        = 0;
      was_valid      = 0;
    end else begin
      if (bus.out_valid) begin
        if (!was_valid && first_pending) begin
          check("first_valid_latency", int'(cyc - close_cyc), 258);
          first_pending = 0;
        end
        if (stalled) begin
          check("stall_hold_data", bus.out_data, held_data);
          check("stall_hold_last", bus.out_last, held_last);
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got data %0d with no expected beat queued", $signed(bus.out_data));
          end else begin
            exp_beat_t e;
            e = exp_q.pop_front();
            check($sformatf("beat%0d_data", beats_in_frame), int'($signed(bus.out_data)), int'($signed(e.data)));
            check($sformatf("beat%0d_last", beats_in_frame), bus.out_last, e.last);
          end
          beats_in_frame++;
          if (bus.out_last) begin
            check("beats_per_frame", beats_in_frame, 32);
            beats_in_frame = 0;
          end
          stalled = 0;
        end else begin
          stalled   = 1;
          held_data = bus.out_data;
          held_last = bus.out_last;
        end
      end else begin
        if (stalled) check("valid_held_in_stall", bus.out_valid, 1);
        stalled = 0;
      end
      was_valid = bus.out_valid;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode && stall_left > 0 && beats_in_frame == 5 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2[16];
    int imp[16];
    int dc[16];
    int four[16];
    int rx[16];
    t2 = '{-7, -10, -7, 0, 7, 10, 7, 0, -7, -10, -7, 0, 7, 10, 7, 0};
    for (int i = 0; i < 16; i++) begin
      cos_t[i] = int'(128.0 * $cos(2.0 * 3.14159265358979 * i / 16.0));
      sin_t[i] = int'(128.0 * $sin(2.0 * 3.14159265358979 * i / 16.0));
      imp[i]  = (i == 0) ? 127 : 0;
      dc[i]   = 100;
      four[i] = (i < 4) ? 16 : 0;
    end
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;
    bus.in_last      = 1'b0;
    bus.config_data  = '0;
    bus.config_valid = 1'b0;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      reset_outputs_check("reset");
    end
    rst = 1'b0;
    idle(1);
    check("post_reset_in_ready", bus.in_ready, 1);
    check("post_reset_config_ready", bus.config_ready, 1);

    run_frame(t2, 16, 1, 1, 8'h01, 0, 0);
    run_frame(imp, 16, 1, 0, 8'h00, 0, 0);
    run_frame(dc, 16, 0, 0, 8'h00, 0, 0);
    run_frame(four, 4, 1, 0, 8'h00, 0, 0);

    for (int i = 0; i < 16; i++) rx[i] = int'($urandom_range(0, 255)) - 128;
    stall_mode = 1;
    stall_left = 10;
    run_frame(rx, 16, 1, 0, 8'h00, 0, 0);
    check("stall_cycles_applied", stall_left, 0);
    stall_mode = 0;

    run_frame(t2, 16, 1, 1, 8'h00, 0, 0);
    run_frame(t2, 16, 1, 2, 8'hFF, 1, 0);
    run_frame(t2, 16, 1, 1, 8'hFE, 0, 1);
    run_frame(t2, 16, 1, 0, 8'h00, 0, 0);

    rand_ready = 1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) rx[i] = int'($urandom_range(0, 255)) - 128;
      run_frame(rx, int'($urandom_range(1, 16)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 0);
    end
    rand_ready = 0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
